uart_core: RTL
==============

# uart_core

Parametrised, self-contained UART endpoint for the debug transport: TX/RX serial engines plus one FIFO per direction, generic in data width, FIFO depth and stop bits. It sits between the board RX/TX pins and the debug-module bus logic, which pushes and pops words through a simple write/read strobe interface. Unlike the fixed 8-bit endpoint, it reports FIFO fill levels and sticky overrun/framing errors, and it rejects start-bit glitches.

## Interface
- CLK_RATE, 100_000_000, system clock frequency in Hz
- BAUD_RATE, 115200, line rate; DIV = CLK_RATE/BAUD_RATE (truncated), DIV ≥ 4
- DATA_W, 8, data bits per frame, 5..9, sent LSB first
- FIFO_DEPTH, 16, entries per FIFO, power of two, ≥ 2
- STOP_BITS, 1, stop bits, 1 or 2 (RX checks only the first)
- CLK_I  in  1  system clock, rising edge
- RST_NI  in  1  asynchronous active-low reset
- WE_I  in  1  push DSEND_I into TX FIFO
- DSEND_I  in  DATA_W  TX data
- TX_READY_O  out  1  TX FIFO not full
- TX_LEVEL_O  out  $clog2(FIFO_DEPTH+1)  TX FIFO occupancy
- RE_I  in  1  pop RX FIFO head
- DREC_O  out  DATA_W  RX FIFO head (first-word fall-through), 0 when empty
- RX_EMPTY_O  out  1  RX FIFO empty
- RX_FULL_O  out  1  RX FIFO full
- RX_LEVEL_O  out  $clog2(FIFO_DEPTH+1)  RX FIFO occupancy
- OVERRUN_O  out  1  sticky: a received word was dropped because the RX FIFO was full
- FRAME_ERR_O  out  1  sticky: stop bit sampled low
- PARITY_ERR_O  out  1  sticky: parity mismatch (0 without UART_PARITY_EN)
- CLR_ERR_I  in  1  clears all sticky flags
- RX_I  in  1  serial input, asynchronous
- TX_O  out  1  serial output, registered

## Operation
- Reset (asynchronous): TX_O=1, TX_READY_O=1, RX_EMPTY_O=1, RX_FULL_O=0, levels=0, all error flags 0, DREC_O=0, both FSMs IDLE, FIFOs empty. Reset mid-frame aborts the frame immediately; TX_O returns to 1.
- TX FIFO: WE_I while full is ignored (no level change, no corruption).
- TX FSM: IDLE→START→DATA(DATA_W bits)→[PARITY]→STOP(STOP_BITS bits)→IDLE. In IDLE with the FIFO non-empty, pop the head into the shift register and enter START. Each bit lasts exactly DIV cycles. A non-empty FIFO sends frames back to back with no idle bit.
- RX input passes through a 2-FF synchronizer; all sampling uses the synchronized value.
- RX FSM: IDLE→START on a 1→0 edge. At DIV/2 cycles, a low sample confirms the start bit; a high sample is a glitch and returns the FSM to IDLE with no flag. DATA bits are then sampled every DIV cycles at mid-bit, followed by [PARITY] and STOP.
- At the stop sample: low sets FRAME_ERR_O and discards the word. A high stop with a parity error sets PARITY_ERR_O and discards the word. Otherwise the word is pushed. A push into a full FIFO without a simultaneous RE_I drops the word and sets OVERRUN_O.
- The FSM returns to IDLE at the stop-bit midpoint, so the next start edge is accepted.
- RX FIFO: RE_I while empty is ignored. Push and pop in the same cycle leave the level unchanged, including when the FIFO is full.
- CLR_ERR_I clears the flags on the next edge. If an error event occurs in the same cycle, the set wins.

## Timing
- WE_I at cycle 0 into an empty TX FIFO with the FSM idle: level 1 at cycle 1, FSM pops at cycle 1, TX_O=0 from cycle 2 for DIV cycles.
- Frame length is (1+DATA_W+P+STOP_BITS)·DIV cycles, where P=1 with parity and 0 otherwise.
- RX word is visible on DREC_O / RX_EMPTY_O=0 two cycles after the stop-bit mid-sample (one cycle for the push, one for the flag register). Synchronizer latency is 2 cycles.
- DREC_O and the flags are registered and change only on CLK_I edges.
- Level counters are saturation-free; FIFO pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.

## Configuration
- UART_PARITY_EN defined: an even-parity bit follows the data bits on TX and is checked on RX; PARITY_ERR_O is live.
- UART_PARITY_EN undefined: no parity bit is sent or expected, and PARITY_ERR_O is tied to 0.

## Test plan
- CLK_RATE=1_000_000, BAUD_RATE=100_000 (DIV=10), no parity: write 0xA5 -> TX_O low at cycle 2, bits 1,0,1,0,0,1,0,1 each 10 cycles, then high; total frame 100 cycles.
- Loop TX_O to RX_I and write 0x00, 0xFF, 0x3C -> RX_LEVEL_O reaches 3; three RE_I pops return 0x00, 0xFF, 0x3C; RX_EMPTY_O=1 after the last pop.
- FIFO_DEPTH=4: send 5 words with no reads -> RX_FULL_O=1, OVERRUN_O=1, first 4 words intact; CLR_ERR_I pulse -> OVERRUN_O=0.
- Drive a 3-cycle low glitch on RX_I -> no push, no flags; then a frame with stop bit 0 -> FRAME_ERR_O=1, RX_EMPTY_O stays 1.
- With UART_PARITY_EN, send 0x07 with a parity bit of 0 -> PARITY_ERR_O=1 and the word is discarded; correct parity 1 -> 0x07 received.
- Assert RST_NI low mid-frame at bit 3 -> TX_O=1 and all flags and levels 0 immediately; after release the next written word is sent intact.

Source files
------------

// File: rtl/uart_core.sv
// rtl/uart_core.sv - UART endpoint with TX/RX FIFOs, sticky errors, glitch-rejecting RX; even parity when UART_PARITY_EN is defined
module uart_core #(
  parameter int CLK_RATE   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                               CLK_I,
  input  logic                               RST_NI,
  input  logic                               WE_I,
  input  logic [DATA_W-1:0]                  DSEND_I,
  output logic                               TX_READY_O,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    TX_LEVEL_O,
  input  logic                               RE_I,
  output logic [DATA_W-1:0]                  DREC_O,
  output logic                               RX_EMPTY_O,
  output logic                               RX_FULL_O,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    RX_LEVEL_O,
  output logic                               OVERRUN_O,
  output logic                               FRAME_ERR_O,
  output logic                               PARITY_ERR_O,
  input  logic                               CLR_ERR_I,
  input  logic                               RX_I,
  output logic                               TX_O
);

  localparam int DIV = CLK_RATE / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_W);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] DIV_HALF  = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [PW-1:0] FULL_FILL = PW'(FIFO_DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0]     tx_wr, tx_rd, tx_fill;
  logic              tx_full, tx_empty;

  assign tx_fill    = tx_wr - tx_rd;
  assign tx_full    = (tx_fill == FULL_FILL);
  assign tx_empty   = (tx_fill == '0);
  assign TX_READY_O = !tx_full;
  assign TX_LEVEL_O = LW'(tx_fill);

  // TX storage: writes while full are dropped without touching the array
  always_ff @(posedge CLK_I) begin
    if (WE_I && !tx_full) tx_mem[tx_wr[AW-1:0]] <= DSEND_I;
  end

  // TX write pointer
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI)                tx_wr <= '0;
    else if (WE_I && !tx_full)  tx_wr <= tx_wr + 1'b1;
  end

  // ---------------- TX FSM ----------------
  state_t            tx_state;
  logic [CW-1:0]     tx_div;
  logic [BW-1:0]     tx_bit;
  logic              tx_stop;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_q;
`ifdef UART_PARITY_EN
  logic              tx_par;
`endif

  // TX serializer; stop-bit exit reloads directly so queued frames run back to back
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      tx_state <= ST_IDLE;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_shift <= '0;
      tx_rd    <= '0;
      tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!tx_empty) begin
            tx_shift <= tx_mem[tx_rd[AW-1:0]];
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_mem[tx_rd[AW-1:0]];
`endif
            tx_rd    <= tx_rd + 1'b1;
            tx_q     <= 1'b0;
            tx_div   <= '0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_div == DIV_LAST) begin
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_q     <= tx_shift[0];
            tx_state <= ST_DATA;
          end else begin
            tx_div <= tx_div + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_div == DIV_LAST) begin
            tx_div <= '0;
            if (tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
              tx_q     <= tx_par;
              tx_state <= ST_PAR;
`else
              tx_q     <= 1'b1;
              tx_stop  <= 1'b0;
              tx_state <= ST_STOP;
`endif
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= tx_shift >> 1;
              tx_q     <= tx_shift[1];
            end
          end else begin
            tx_div <= tx_div + 1'b1;
          end
        end
        ST_PAR: begin
          if (tx_div == DIV_LAST) begin
            tx_div   <= '0;
            tx_q     <= 1'b1;
            tx_stop  <= 1'b0;
            tx_state <= ST_STOP;
          end else begin
            tx_div <= tx_div + 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_div == DIV_LAST) begin
            tx_div <= '0;
            if (tx_stop == STOP_LAST) begin
              if (!tx_empty) begin
                tx_shift <= tx_mem[tx_rd[AW-1:0]];
`ifdef UART_PARITY_EN
                tx_par   <= ^tx_mem[tx_rd[AW-1:0]];
`endif
                tx_rd    <= tx_rd + 1'b1;
                tx_q     <= 1'b0;
                tx_state <= ST_START;
              end else begin
                tx_state <= ST_IDLE;
              end
            end else begin
              tx_stop <= 1'b1;
            end
          end else begin
            tx_div <= tx_div + 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  assign TX_O = tx_q;

  // ---------------- RX front end ----------------
  logic rx_s1, rx_s2, rx_prev;

  // two-flop synchronizer plus one stage of history for start-edge detection
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX_I;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // ---------------- RX FSM ----------------
  state_t            rx_state;
  logic [CW-1:0]     rx_div;
  logic [BW-1:0]     rx_bit;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_push;
  logic [DATA_W-1:0] rx_push_data;
  logic              frame_err_q;
`ifdef UART_PARITY_EN
  logic              rx_par_bad;
  logic              parity_err_q;
`endif

  // RX deserializer; error flag sets are written after the clear so a coincident set wins
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      rx_state     <= ST_IDLE;
      rx_div       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_push      <= 1'b0;
      rx_push_data <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_push <= 1'b0;
      if (CLR_ERR_I) begin
        frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
        parity_err_q <= 1'b0;
`endif
      end
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_div   <= '0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_div == DIV_HALF) begin
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
          end else begin
            rx_div <= rx_div + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_div == DIV_LAST) begin
            rx_div   <= '0;
            rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
            if (rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
              rx_state <= ST_PAR;
`else
              rx_state <= ST_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_div <= rx_div + 1'b1;
          end
        end
        ST_PAR: begin
          if (rx_div == DIV_LAST) begin
            rx_div   <= '0;
`ifdef UART_PARITY_EN
            rx_par_bad <= rx_s2 ^ (^rx_shift);
`endif
            rx_state <= ST_STOP;
          end else begin
            rx_div <= rx_div + 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_div == DIV_LAST) begin
            rx_div   <= '0;
            rx_state <= ST_IDLE;
            if (!rx_s2) begin
              frame_err_q <= 1'b1;
            end
`ifdef UART_PARITY_EN
            else if (rx_par_bad) begin
              parity_err_q <= 1'b1;
            end
`endif
            else begin
              rx_push      <= 1'b1;
              rx_push_data <= rx_shift;
            end
          end else begin
            rx_div <= rx_div + 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  assign FRAME_ERR_O = frame_err_q;
`ifdef UART_PARITY_EN
  assign PARITY_ERR_O = parity_err_q;
`else
  assign PARITY_ERR_O = 1'b0;
`endif

  // ---------------- RX FIFO ----------------
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0]     rx_wr, rx_rd, rx_fill;
  logic [PW-1:0]     rx_wr_nx, rx_rd_nx, rx_fill_nx;
  logic              rx_do_pop, rx_do_push, rx_drop;
  logic [LW-1:0]     rx_lvl_q;
  logic              rx_empty_q, rx_full_q, overrun_q;
  logic [DATA_W-1:0] drec_q;

  assign rx_fill    = rx_wr - rx_rd;
  assign rx_do_pop  = RE_I && (rx_fill != '0);
  assign rx_do_push = rx_push && ((rx_fill != FULL_FILL) || rx_do_pop);
  assign rx_drop    = rx_push && !rx_do_push;
  assign rx_wr_nx   = rx_wr + PW'(rx_do_push);
  assign rx_rd_nx   = rx_rd + PW'(rx_do_pop);
  assign rx_fill_nx = rx_wr_nx - rx_rd_nx;

  // RX storage
  always_ff @(posedge CLK_I) begin
    if (rx_do_push) rx_mem[rx_wr[AW-1:0]] <= rx_push_data;
  end

  // RX pointers and registered status; the head register looks ahead to the post-edge state
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      rx_wr      <= '0;
      rx_rd      <= '0;
      rx_lvl_q   <= '0;
      rx_empty_q <= 1'b1;
      rx_full_q  <= 1'b0;
      drec_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      rx_wr      <= rx_wr_nx;
      rx_rd      <= rx_rd_nx;
      rx_lvl_q   <= LW'(rx_fill_nx);
      rx_empty_q <= (rx_fill_nx == '0);
      rx_full_q  <= (rx_fill_nx == FULL_FILL);
      if (rx_fill_nx == '0)                           drec_q <= '0;
      else if (rx_do_push && (rx_fill_nx == PW'(1)))  drec_q <= rx_push_data;
      else                                            drec_q <= rx_mem[rx_rd_nx[AW-1:0]];
      if (CLR_ERR_I) overrun_q <= 1'b0;
      if (rx_drop)   overrun_q <= 1'b1;
    end
  end

  assign DREC_O     = drec_q;
  assign RX_EMPTY_O = rx_empty_q;
  assign RX_FULL_O  = rx_full_q;
  assign RX_LEVEL_O = rx_lvl_q;
  assign OVERRUN_O  = overrun_q;

endmodule
